deteccion_tecla: RTL and testbench

DETECCION_TECLA -- requirements
Module: deteccion_tecla

---
 rtl/deteccion_tecla_pkg.sv | 18 +
 rtl/deteccion_tecla.sv | 108 ++++++++++
 tb/tb_deteccion_tecla.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/deteccion_tecla_pkg.sv
// Shared types and default scan-code constants for the PS/2 key-release detector.
// Optional feature macro: DETECCION_TECLA_EXT_EN (adds the extended-key wait state).
package deteccion_tecla_pkg;

    localparam logic [7:0] BREAK_CODE_DEF = 8'hF0;
    localparam logic [7:0] EXT_CODE_DEF   = 8'hE0;

    typedef enum logic [1:0] {
        ESPERA_BRK  = 2'd0,
`ifdef DETECCION_TECLA_EXT_EN
        OBTENER_COD = 2'd1,
        ESPERA_EXT  = 2'd2
`else
        OBTENER_COD = 2'd1
`endif
    } estado_t;

endpackage

// File: rtl/deteccion_tecla.sv
// PS/2 key-release detector: waits for the break prefix, then latches the
// following code byte into tecla and pulses got_done_tick for one cycle.
// Optional feature macro: DETECCION_TECLA_EXT_EN adds tecla_ext, which marks
// releases of extended keys (EXT_CODE, BREAK_CODE, code).
module deteccion_tecla
    import deteccion_tecla_pkg::*;
#(
    parameter logic [7:0] BREAK_CODE = BREAK_CODE_DEF,
    parameter logic [7:0] EXT_CODE   = EXT_CODE_DEF
) (
    input  logic       clk_Nexys,
    input  logic       Reset,
    input  logic [7:0] byte_dato,
    input  logic       scan_done_tick,
`ifdef DETECCION_TECLA_EXT_EN
    output logic       tecla_ext,
`endif
    output logic [7:0] tecla,
    output logic       got_done_tick
);

    estado_t    estado_q;
    estado_t    estado_d;
    logic [7:0] tecla_d;
    logic       got_d;
    logic       es_break;

`ifdef DETECCION_TECLA_EXT_EN
    logic       ext_flag_q;
    logic       ext_flag_d;
    logic       tecla_ext_d;
    logic       es_ext;

    assign es_ext = (byte_dato == EXT_CODE);
`endif

    assign es_break = (byte_dato == BREAK_CODE);

    // State and output registers; reset wins over any byte arriving on the same edge.
    always_ff @(posedge clk_Nexys) begin
        if (Reset) begin
            estado_q      <= ESPERA_BRK;
            tecla         <= 8'h00;
            got_done_tick <= 1'b0;
`ifdef DETECCION_TECLA_EXT_EN
            ext_flag_q    <= 1'b0;
            tecla_ext     <= 1'b0;
`endif
        end else begin
            estado_q      <= estado_d;
            tecla         <= tecla_d;
            got_done_tick <= got_d;
`ifdef DETECCION_TECLA_EXT_EN
            ext_flag_q    <= ext_flag_d;
            tecla_ext     <= tecla_ext_d;
`endif
        end
    end

    // Next-state and next-output decode; nothing moves unless a byte was received.
    always_comb begin
        estado_d    = estado_q;
        tecla_d     = tecla;
        got_d       = 1'b0;
`ifdef DETECCION_TECLA_EXT_EN
        ext_flag_d  = ext_flag_q;
        tecla_ext_d = tecla_ext;
`endif
        if (scan_done_tick) begin
            case (estado_q)
                ESPERA_BRK: begin
                    if (es_break) begin
                        estado_d   = OBTENER_COD;
`ifdef DETECCION_TECLA_EXT_EN
                        ext_flag_d = 1'b0;
                    end else if (es_ext) begin
                        estado_d   = ESPERA_EXT;
`endif
                    end
                end
                OBTENER_COD: begin
                    if (!es_break) begin
                        estado_d    = ESPERA_BRK;
                        tecla_d     = byte_dato;
                        got_d       = 1'b1;
`ifdef DETECCION_TECLA_EXT_EN
                        tecla_ext_d = ext_flag_q;
`endif
                    end
                end
`ifdef DETECCION_TECLA_EXT_EN
                ESPERA_EXT: begin
                    if (es_break) begin
                        estado_d   = OBTENER_COD;
                        ext_flag_d = 1'b1;
                    end else begin
                        estado_d   = ESPERA_BRK;
                    end
                end
`endif
                default: begin
                    estado_d = ESPERA_BRK;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deteccion_tecla.sv
// Self-checking bench for deteccion_tecla: directed scenarios plus random byte
// streams compared against a byte-history reference model.
// Optional feature macro: DETECCION_TECLA_EXT_EN enables the extended-key scenario.
module tb_deteccion_tecla;

    logic       clk_Nexys;
    logic       Reset;
    logic [7:0] byte_dato;
    logic       scan_done_tick;
    logic [7:0] tecla;
    logic       got_done_tick;
`ifdef DETECCION_TECLA_EXT_EN
    logic       tecla_ext;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: every byte accepted since the last reset, in order.
    logic [7:0] hist[$];
    logic [7:0] exp_tecla;
    logic       exp_got;
    logic       exp_ext;

    deteccion_tecla dut (
        .clk_Nexys     (clk_Nexys),
        .Reset         (Reset),
        .byte_dato     (byte_dato),
        .scan_done_tick(scan_done_tick),
`ifdef DETECCION_TECLA_EXT_EN
        .tecla_ext     (tecla_ext),
`endif
        .tecla         (tecla),
        .got_done_tick (got_done_tick)
    );

    // Free-running system clock.
    initial clk_Nexys = 1'b0;
    always #5 clk_Nexys = ~clk_Nexys;

    // A release is extended when the byte just before the F0 run is an E0
    // that itself arrived while idle (not right after F0 or another E0).
    function automatic logic ext_of_history();
        int j;
        j = hist.size() - 1;
        while (j >= 0 && hist[j] == 8'hF0) j--;
        if (j < 0) return 1'b0;
        if (hist[j] != 8'hE0) return 1'b0;
        if (j == 0) return 1'b1;
        return (hist[j-1] != 8'hF0) && (hist[j-1] != 8'hE0);
    endfunction

    // Drive one cycle of inputs, advance the model past the edge, settle #1 after it.
    task automatic apply_stimulus(input logic rst, input logic tick, input logic [7:0] b);
        @(negedge clk_Nexys);
        Reset          = rst;
        scan_done_tick = tick;
        byte_dato      = b;
        @(posedge clk_Nexys);
        if (rst) begin
            hist.delete();
            exp_tecla = 8'h00;
            exp_got   = 1'b0;
            exp_ext   = 1'b0;
        end else begin
            exp_got = 1'b0;
            if (tick) begin
                if (b != 8'hF0 && hist.size() > 0 && hist[hist.size()-1] == 8'hF0) begin
                    exp_tecla = b;
                    exp_got   = 1'b1;
                    exp_ext   = ext_of_history();
                end
                hist.push_back(b);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 1'b1, 8'hF0);
            checks++;
            if (tecla !== 8'h00 || got_done_tick !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_hold cyc %0d: tecla=%h got=%b, want 00/0", i, tecla, got_done_tick);
            end
        end
        apply_stimulus(1'b0, 1'b1, 8'h1C);
        checks++;
        if (tecla !== exp_tecla || got_done_tick !== exp_got || got_done_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: tecla=%h got=%b, want %h/0", tecla, got_done_tick, exp_tecla);
        end
    endtask

    task automatic test_make_break();
        logic [7:0] seq[3] = '{8'h1C, 8'hF0, 8'h1C};
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 1'b1, seq[i]);
            checks++;
            if (got_done_tick !== exp_got || tecla !== exp_tecla) begin
                errors++;
                $display("[TB] FAIL make_break byte %0d: tecla=%h got=%b, want %h/%b", i, tecla, got_done_tick, exp_tecla, exp_got);
            end
            if (got_done_tick === 1'b1) pulses++;
            apply_stimulus(1'b0, 1'b0, 8'h00);
            if (got_done_tick === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || tecla !== 8'h1C) begin
            errors++;
            $display("[TB] FAIL make_break_total: pulses=%0d tecla=%h, want 1/1c", pulses, tecla);
        end
    endtask

    task automatic test_repeated_prefix();
        logic [7:0] seq[4] = '{8'hF0, 8'hF0, 8'hF0, 8'h1C};
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b0, 1'b1, seq[i]);
            checks++;
            if (got_done_tick !== exp_got || tecla !== exp_tecla) begin
                errors++;
                $display("[TB] FAIL repeated_prefix byte %0d: tecla=%h got=%b, want %h/%b", i, tecla, got_done_tick, exp_tecla, exp_got);
            end
            if (got_done_tick === 1'b1) pulses++;
            apply_stimulus(1'b0, 1'b0, 8'h00);
            if (got_done_tick === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1 || tecla !== 8'h1C) begin
            errors++;
            $display("[TB] FAIL repeated_prefix_total: pulses=%0d tecla=%h, want 1/1c", pulses, tecla);
        end
    endtask

    task automatic test_reset_abort();
        apply_stimulus(1'b0, 1'b1, 8'hF0);
        apply_stimulus(1'b1, 1'b0, 8'h00);
        apply_stimulus(1'b0, 1'b1, 8'h32);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (got_done_tick !== 1'b0 || tecla !== 8'h00 || tecla !== exp_tecla) begin
                errors++;
                $display("[TB] FAIL reset_abort cyc %0d: tecla=%h got=%b, want 00/0", i, tecla, got_done_tick);
            end
            apply_stimulus(1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic test_hold();
        apply_stimulus(1'b0, 1'b1, 8'hF0);
        apply_stimulus(1'b0, 1'b1, 8'h1C);
        checks++;
        if (got_done_tick !== 1'b1 || tecla !== 8'h1C) begin
            errors++;
            $display("[TB] FAIL hold_pulse: tecla=%h got=%b, want 1c/1", tecla, got_done_tick);
        end
        for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b0, 1'b0, 8'hF0);
            checks++;
            if (got_done_tick !== 1'b0 || tecla !== 8'h1C) begin
                errors++;
                $display("[TB] FAIL hold_idle cyc %0d: tecla=%h got=%b, want 1c/0", i, tecla, got_done_tick);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[8] = '{8'hF0, 8'h1C, 8'hF0, 8'h32, 8'h5A, 8'hF0, 8'hF0, 8'h66};
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1'b0, 1'b1, seq[i]);
            checks++;
            if (got_done_tick !== exp_got || tecla !== exp_tecla) begin
                errors++;
                $display("[TB] FAIL back_to_back byte %0d: tecla=%h got=%b, want %h/%b", i, tecla, got_done_tick, exp_tecla, exp_got);
            end
        end
    endtask

    task automatic test_random();
        logic       rst;
        logic       tick;
        logic [7:0] b;
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 39) == 0);
            tick = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 2) == 0) begin
                b = 8'hF0;
            end else begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'hE0) b = 8'h1C;
            end
            apply_stimulus(rst, tick, b);
            checks++;
            if (got_done_tick !== exp_got || tecla !== exp_tecla) begin
                errors++;
                $display("[TB] FAIL random cyc %0d: tecla=%h got=%b, want %h/%b", i, tecla, got_done_tick, exp_tecla, exp_got);
            end
`ifdef DETECCION_TECLA_EXT_EN
            checks++;
            if (tecla_ext !== exp_ext) begin
                errors++;
                $display("[TB] FAIL random_ext cyc %0d: tecla_ext=%b, want %b", i, tecla_ext, exp_ext);
            end
`endif
        end
    endtask

`ifdef DETECCION_TECLA_EXT_EN
    task automatic test_ext();
        logic [7:0] seq[5] = '{8'hE0, 8'hF0, 8'h74, 8'hF0, 8'h1C};
        apply_stimulus(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 1'b1, seq[i]);
            checks++;
            if (got_done_tick !== exp_got || tecla !== exp_tecla || tecla_ext !== exp_ext) begin
                errors++;
                $display("[TB] FAIL ext byte %0d: tecla=%h ext=%b got=%b, want %h/%b/%b", i, tecla, tecla_ext, got_done_tick, exp_tecla, exp_ext, exp_got);
            end
            if (i == 2) begin
                checks++;
                if (tecla !== 8'h74 || tecla_ext !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL ext_release: tecla=%h ext=%b, want 74/1", tecla, tecla_ext);
                end
            end
            if (i == 4) begin
                checks++;
                if (tecla !== 8'h1C || tecla_ext !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL plain_release: tecla=%h ext=%b, want 1c/0", tecla, tecla_ext);
                end
            end
        end
    endtask
`endif

    // Scenario sequence and final summary.
    initial begin
        Reset          = 1'b1;
        scan_done_tick = 1'b0;
        byte_dato      = 8'h00;
        exp_tecla      = 8'h00;
        exp_got        = 1'b0;
        exp_ext        = 1'b0;
        test_reset();
        test_make_break();
        test_repeated_prefix();
        test_reset_abort();
        test_hold();
        test_back_to_back();
`ifdef DETECCION_TECLA_EXT_EN
        test_ext();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
